alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised multi-cycle ALU, successor to the single-cycle combinational ALU in the execute stage.
- Adds a configurable operand width and a valid/ready handshake on both sides.
- Replaces the combinational multiplier with an iterative shift-add multiplier and adds unsigned iterative division.
- Sits between decode/issue and writeback; the pipeline stalls on ready_o.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived, not overridden).

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  request valid.
- ready_o  out  1  block can accept a request.
- data1_i  in  WIDTH  operand A.
- data2_i  in  WIDTH  operand B.
- ALUCtrl_i  in  3  opcode.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- data_o  out  WIDTH  result.
- Zero_o  out  1  operands equal.

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous, active-high.
- Opcodes:
  - 001 SUM, 010 SUB, 011 AND, 100 OR, 101 XOR: single-cycle.
  - 110 MUL: low WIDTH bits of the product, iterative.
  - 111 DIVU: unsigned quotient, iterative.
  - 000: pass data1_i.
- All arithmetic is modulo 2^WIDTH; no overflow flag.
- States: IDLE, BUSY, DONE.
- ready_o = (state == IDLE). Accept = valid_i & ready_o. On accept, capture operands and opcode; later input changes are ignored.
- IDLE:
  - Accept of a single-cycle op: compute, register data_o, go to DONE. valid_o is high in the cycle after accept (latency 1).
  - Accept of MUL/DIVU: load iteration counter = WIDTH, go to BUSY.
- BUSY:
  - One iteration per cycle: shift-add for MUL, restoring step for DIVU. Counter decrements each cycle.
  - When counter reaches 1, the final iteration writes data_o and the state goes to DONE. valid_o first rises WIDTH+1 cycles after accept (33 for WIDTH=32).
  - valid_i is ignored (ready_o=0).
- DONE:
  - valid_o=1; data_o and Zero_o are held stable while ready_i=0.
  - On ready_i=1, go to IDLE; valid_o drops next cycle.
  - No same-cycle result-drain/new-accept; maximum throughput is one single-cycle op per 2 cycles.
- Zero_o: 1 iff captured data1 == data2 (all WIDTH bits); registered with data_o, valid only while valid_o=1.
- DIVU by zero: quotient = all ones (e.g. 0xFFFF_FFFF), same latency, no exception. The remainder is discarded.
- Reset:
  - rst_i high in any cycle: next state IDLE, valid_o=0, data_o=0, Zero_o=0, counter=0, operand registers=0.
  - ready_o=1 from the cycle after reset is sampled.
  - valid_i is ignored in a cycle where rst_i=1.
  - Reset mid-BUSY aborts the operation; no result is ever presented for it.
- No X propagation: data_o must hold its last value outside DONE; it must not be recomputed combinationally from inputs.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants: ALU_PASS, ALU_SUM, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_MUL, ALU_DIVU (3-bit).
  - State encoding: ST_IDLE, ST_BUSY, ST_DONE (2-bit).
  - Used by decode and this block.
- Sub-module alu_iter_muldiv(WIDTH):
  - Holds the accumulator/partial-remainder and shift registers.
  - Inputs: start, op_is_div, operands.
  - Outputs: done, result.
- alu_mc keeps the handshake FSM, single-cycle datapath and output registers.

Test Plan:
- SUM: valid_i with 5 + 7 -> valid_o next cycle, data_o=12, Zero_o=0; 0xFFFF_FFFF + 1 -> data_o=0.
- SUB and equality: 9 - 9 -> data_o=0, Zero_o=1; 3 - 5 -> data_o=0xFFFF_FFFE, Zero_o=0.
- MUL: 0xFFFF_FFFF * 3 -> ready_o low for 32 cycles, valid_o at accept+33, data_o=0xFFFF_FFFD; 1234 * 5678 -> 7006652.
- DIVU: 100 / 7 -> data_o=14 at accept+33; 5 / 0 -> data_o=0xFFFF_FFFF.
- Backpressure: SUM 1+1 with ready_i=0 for 5 cycles -> data_o=2 and valid_o held, ready_o=0, a second valid_i during this time is not accepted; ready_i=1 -> valid_o=0 and ready_o=1 next cycle.
- Reset: rst_i pulse 10 cycles into a MUL -> next cycle valid_o=0, data_o=0, ready_o=1; no stale result appears over the following 40 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_pkg : opcodes and FSM state encoding shared by decode/ALU    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package alu_pkg;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_SUM  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_MUL  = 3'b110;
    localparam logic [2:0] ALU_DIVU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mc_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_mc_if : issue-side request and writeback-side result bundle  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic [2:0]       ALUCtrl_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] data_o;
    logic             Zero_o;

    modport master (
        output valid_i, data1_i, data2_i, ALUCtrl_i, ready_i,
        input  ready_o, valid_o, data_o, Zero_o
    );

    modport slave (
        input  valid_i, data1_i, data2_i, ALUCtrl_i, ready_i,
        output ready_o, valid_o, data_o, Zero_o
    );
endinterface
`default_nettype wire

// File: rtl/alu_iter_muldiv.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_iter_muldiv : WIDTH-step shift-add multiply / restoring divu |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module alu_iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    input  wire logic             op_is_div,
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    output logic                  done,
    output logic [WIDTH-1:0]      result
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    // r_a: accumulator / partial remainder, r_b: multiplicand / divisor,
    // r_c: multiplier / dividend shifting into quotient
    logic [CNT_W-1:0] r_cnt;
    logic             r_div;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;

    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    logic [WIDTH-1:0] w_c_next;

    always_comb begin
        w_rem_sh = {r_a, r_c[WIDTH-1]};
        // A zero divisor always compares as fitting, giving an all-ones quotient
        w_ge     = (w_rem_sh >= {1'b0, r_b});
        w_diff   = w_rem_sh[WIDTH-1:0] - r_b;
        if (r_div) begin
            w_a_next = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
            w_b_next = r_b;
            w_c_next = {r_c[WIDTH-2:0], w_ge};
        end else begin
            w_a_next = r_c[0] ? (r_a + r_b) : r_a;
            w_b_next = r_b << 1;
            w_c_next = r_c >> 1;
        end
    end

    assign done   = (r_cnt == CNT_W'(1));
    assign result = r_div ? w_c_next : w_a_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_div <= 1'b0;
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= '0;
        end else if (start) begin
            r_cnt <= CNT_W'(WIDTH);
            r_div <= op_is_div;
            r_a   <= '0;
            r_b   <= op_is_div ? b : a;
            r_c   <= op_is_div ? a : b;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
            r_a   <= w_a_next;
            r_b   <= w_b_next;
            r_c   <= w_c_next;
        end
    end
endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_mc : multi-cycle ALU with valid/ready on request and result  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    alu_mc_if.slave   bus
);
    alu_state_e       r_state;
    alu_state_e       w_state_next;
    logic             w_accept;
    logic             w_iter_op;
    logic             w_equal;
    logic             w_mdone;
    logic [WIDTH-1:0] w_mresult;
    logic [WIDTH-1:0] w_single;
    logic [WIDTH-1:0] r_data;
    logic             r_zero;
    logic             r_eq;

    assign w_accept  = bus.valid_i && (r_state == ST_IDLE);
    assign w_iter_op = is_iter_op(bus.ALUCtrl_i);
    assign w_equal   = (bus.data1_i == bus.data2_i);

    always_comb begin
        w_single = bus.data1_i;
        case (bus.ALUCtrl_i)
            ALU_SUM: w_single = bus.data1_i + bus.data2_i;
            ALU_SUB: w_single = bus.data1_i - bus.data2_i;
            ALU_AND: w_single = bus.data1_i & bus.data2_i;
            ALU_OR:  w_single = bus.data1_i | bus.data2_i;
            ALU_XOR: w_single = bus.data1_i ^ bus.data2_i;
            default: w_single = bus.data1_i;
        endcase
    end

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk       (clk_i),
        .rst       (rst_i),
        .start     (w_accept && w_iter_op),
        .op_is_div (bus.ALUCtrl_i == ALU_DIVU),
        .a         (bus.data1_i),
        .b         (bus.data2_i),
        .done      (w_mdone),
        .result    (w_mresult)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = w_iter_op ? ST_BUSY : ST_DONE;
            ST_BUSY: if (w_mdone) w_state_next = ST_DONE;
            ST_DONE: if (bus.ready_i) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Equality is latched at accept so Zero_o tracks the captured operands
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data <= '0;
            r_zero <= 1'b0;
            r_eq   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_eq <= w_equal;
            end
            if (w_accept && !w_iter_op) begin
                r_data <= w_single;
                r_zero <= w_equal;
            end else if ((r_state == ST_BUSY) && w_mdone) begin
                r_data <= w_mresult;
                r_zero <= r_eq;
            end
        end
    end

    assign bus.ready_o = (r_state == ST_IDLE);
    assign bus.valid_o = (r_state == ST_DONE);
    assign bus.data_o  = r_data;
    assign bus.Zero_o  = r_zero;
endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_alu_mc : directed self-checking bench for alu_mc (WIDTH=32)   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_alu_mc;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(32)) bus ();

    alu_mc #(
        .WIDTH (32)
    ) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait (bounded) for the result, check it, then drain.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_d, input logic exp_z,
                          input int exp_lat);
        int lat;
        int busy;
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = op;
        bus.data1_i   = a;
        bus.data2_i   = b;
        tick();
        bus.valid_i   = 1'b0;
        bus.data1_i   = ~a;
        bus.data2_i   = b ^ 32'h5A5A_0001;
        bus.ALUCtrl_i = ~op;
        lat  = 1;
        busy = 0;
        while (!bus.valid_o && lat < 100) begin
            if (!bus.ready_o) busy++;
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " ready_lo_cycles"}, 32'(busy), 32'(exp_lat - 1));
        check({tag, " data"}, bus.data_o, exp_d);
        check({tag, " zero"}, {31'b0, bus.Zero_o}, {31'b0, exp_z});
        check({tag, " ready_in_done"}, {31'b0, bus.ready_o}, 32'd0);
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
        check({tag, " drain_valid"}, {31'b0, bus.valid_o}, 32'd0);
        check({tag, " drain_ready"}, {31'b0, bus.ready_o}, 32'd1);
    endtask

    initial begin
        int stale;
        rst           = 1'b1;
        bus.valid_i   = 1'b1;
        bus.ready_i   = 1'b0;
        bus.data1_i   = 32'd3;
        bus.data2_i   = 32'd3;
        bus.ALUCtrl_i = ALU_SUM;
        tick();
        tick();
        check("reset ready", {31'b0, bus.ready_o}, 32'd1);
        check("reset valid", {31'b0, bus.valid_o}, 32'd0);
        check("reset data",  bus.data_o, 32'd0);
        check("reset zero",  {31'b0, bus.Zero_o}, 32'd0);
        bus.valid_i = 1'b0;
        rst         = 1'b0;
        tick();
        check("post_reset valid", {31'b0, bus.valid_o}, 32'd0);

        run_op("sum",      ALU_SUM,  32'd5,          32'd7,          32'd12,         1'b0, 1);
        run_op("sum_wrap", ALU_SUM,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1);
        run_op("sub_eq",   ALU_SUB,  32'd9,          32'd9,          32'd0,          1'b1, 1);
        run_op("sub_neg",  ALU_SUB,  32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 1);
        run_op("and",      ALU_AND,  32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  1'b0, 1);
        run_op("or",       ALU_OR,   32'hF0F0_0000,  32'h0000_1234,  32'hF0F0_1234,  1'b0, 1);
        run_op("xor",      ALU_XOR,  32'hA5A5_A5A5,  32'hFFFF_0000,  32'h5A5A_A5A5,  1'b0, 1);
        run_op("pass",     ALU_PASS, 32'hDEAD_BEEF,  32'd1,          32'hDEAD_BEEF,  1'b0, 1);
        run_op("pass_eq",  ALU_PASS, 32'h77,         32'h77,         32'h77,         1'b1, 1);
        run_op("mul_wrap", ALU_MUL,  32'hFFFF_FFFF,  32'd3,          32'hFFFF_FFFD,  1'b0, 33);
        run_op("mul",      ALU_MUL,  32'd1234,       32'd5678,       32'd7006652,    1'b0, 33);
        run_op("divu",     ALU_DIVU, 32'd100,        32'd7,          32'd14,         1'b0, 33);
        run_op("divu_z",   ALU_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b0, 33);
        run_op("divu_eq",  ALU_DIVU, 32'h8000_0000,  32'h8000_0000,  32'd1,          1'b1, 33);
        run_op("divu_1",   ALU_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, 33);

        // Backpressure: result must hold and a second request must be refused
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = ALU_SUM;
        bus.data1_i   = 32'd1;
        bus.data2_i   = 32'd1;
        tick();
        bus.data1_i   = 32'd10;
        bus.data2_i   = 32'd10;
        for (int i = 0; i < 5; i++) begin
            check("bp valid", {31'b0, bus.valid_o}, 32'd1);
            check("bp data",  bus.data_o, 32'd2);
            check("bp ready", {31'b0, bus.ready_o}, 32'd0);
            tick();
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
        check("bp drain_valid", {31'b0, bus.valid_o}, 32'd0);
        check("bp drain_ready", {31'b0, bus.ready_o}, 32'd1);
        check("bp data_hold",   bus.data_o, 32'd2);
        tick();
        check("bp no_second", {31'b0, bus.valid_o}, 32'd0);

        // Reset 10 cycles into a multiply aborts it for good
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = ALU_MUL;
        bus.data1_i   = 32'd7;
        bus.data2_i   = 32'd9;
        tick();
        bus.valid_i = 1'b0;
        repeat (9) tick();
        check("mid_busy ready", {31'b0, bus.ready_o}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort valid", {31'b0, bus.valid_o}, 32'd0);
        check("abort data",  bus.data_o, 32'd0);
        check("abort ready", {31'b0, bus.ready_o}, 32'd1);
        check("abort zero",  {31'b0, bus.Zero_o}, 32'd0);
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.valid_o) stale++;
            tick();
        end
        check("abort stale", 32'(stale), 32'd0);

        run_op("recover", ALU_SUM, 32'd2, 32'd2, 32'd4, 1'b1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
